mem_loader: RTL and testbench

- Boot-time program loader: the writer that fills the shared program/data memory which the instruction port later reads.
- Receives a byte stream (length header followed by little-endian words) over a valid/ready handshake.
- Drives the memory data-port write signals (memwrite, dataadr, writedata) one word at a time.
- Holds the core in reset until the image is fully written, then releases it.

---
 rtl/mem_loader.sv | 166 ++++++++++++++++
 tb/tb_mem_loader.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_loader.sv
// mem_loader: boot-time loader that writes a length-prefixed little-endian word image into
// memory, then releases the core. Define LOADER_CHECKSUM_EN for a trailing 32-bit checksum word.
//
// state   | meaning
// --------+----------------------------------------------------------
// S_LEN   | collecting the 4-byte word count N
// S_DATA  | collecting the 4 bytes of the next image word
// S_WRITE | one-cycle memwrite strobe for the assembled word
// S_CSUM  | collecting the 4-byte checksum (LOADER_CHECKSUM_EN only)
// S_DONE  | image loaded, core released; terminal until reset
// S_ERR   | bad header or checksum, core held in reset; terminal until reset

module mem_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned MAX_WORDS = 131072,
    parameter int unsigned IDX_W     = $clog2(MAX_WORDS + 1)
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        rx_ready,
    output logic        memwrite,
    output logic [31:0] dataadr,
    output logic [31:0] writedata,
    output logic        core_reset,
    output logic        busy,
    output logic        done,
    output logic        err
);

    localparam logic [2:0] S_LEN   = 3'd0;
    localparam logic [2:0] S_DATA  = 3'd1;
    localparam logic [2:0] S_WRITE = 3'd2;
    localparam logic [2:0] S_DONE  = 3'd3;
    localparam logic [2:0] S_ERR   = 3'd4;
`ifdef LOADER_CHECKSUM_EN
    localparam logic [2:0] S_CSUM  = 3'd5;
`endif

    logic [2:0]       state;
    logic [2:0]       state_nxt;
    logic [1:0]       bcnt;
    logic [23:0]      shreg;
    logic [IDX_W-1:0] n_words;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] idx_inc;
    logic [31:0]      word_in;
    logic [31:0]      idx_byte;
    logic             accept;
    logic             word_last;
    logic             hdr_bad;
`ifdef LOADER_CHECKSUM_EN
    logic [31:0]      csum;
`endif

    assign accept    = rx_valid && rx_ready;
    assign word_last = accept && (bcnt == 2'd3);
    // The three earlier bytes sit in shreg with the oldest in the low byte.
    assign word_in   = {rx_data, shreg};
    assign idx_inc   = idx + IDX_W'(1);
    assign idx_byte  = {{(30 - IDX_W){1'b0}}, idx, 2'b00};
    assign hdr_bad   = (word_in == 32'd0) || (word_in > MAX_WORDS);

    always_comb begin
        state_nxt = state;
        case (state)
            S_LEN: begin
                if (word_last) begin
                    state_nxt = hdr_bad ? S_ERR : S_DATA;
                end
            end
            S_DATA: begin
                if (word_last) begin
                    state_nxt = S_WRITE;
                end
            end
            S_WRITE: begin
                if (idx_inc == n_words) begin
`ifdef LOADER_CHECKSUM_EN
                    state_nxt = S_CSUM;
`else
                    state_nxt = S_DONE;
`endif
                end else begin
                    state_nxt = S_DATA;
                end
            end
`ifdef LOADER_CHECKSUM_EN
            S_CSUM: begin
                if (word_last) begin
                    state_nxt = (word_in == csum) ? S_DONE : S_ERR;
                end
            end
`endif
            S_DONE:  state_nxt = S_DONE;
            S_ERR:   state_nxt = S_ERR;
            default: state_nxt = S_ERR;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_LEN;
            bcnt       <= 2'd0;
            shreg      <= 24'd0;
            n_words    <= '0;
            idx        <= '0;
            rx_ready   <= 1'b0;
            memwrite   <= 1'b0;
            dataadr    <= BASE_ADDR;
            writedata  <= 32'd0;
            core_reset <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            state <= state_nxt;
`ifdef LOADER_CHECKSUM_EN
            rx_ready <= (state_nxt == S_LEN) || (state_nxt == S_DATA) || (state_nxt == S_CSUM);
`else
            rx_ready <= (state_nxt == S_LEN) || (state_nxt == S_DATA);
`endif
            memwrite   <= (state_nxt == S_WRITE);
            done       <= (state_nxt == S_DONE);
            err        <= (state_nxt == S_ERR);
            core_reset <= (state_nxt != S_DONE);

            if (accept) begin
                bcnt  <= bcnt + 2'd1;
                shreg <= {rx_data, shreg[23:8]};
            end

            if ((state_nxt == S_DONE) || (state_nxt == S_ERR)) begin
                busy <= 1'b0;
            end else if ((state == S_LEN) && accept) begin
                busy <= 1'b1;
            end

            if ((state == S_LEN) && word_last) begin
                n_words <= word_in[IDX_W-1:0];
                idx     <= '0;
            end

            if ((state == S_DATA) && word_last) begin
                writedata <= word_in;
                dataadr   <= BASE_ADDR + idx_byte;
            end

            if (state == S_WRITE) begin
                idx <= idx_inc;
            end
        end
    end

`ifdef LOADER_CHECKSUM_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            csum <= 32'd0;
        end else if (state == S_WRITE) begin
            csum <= csum + writedata;
        end
    end
`endif

endmodule

// File: tb/tb_mem_loader.sv
// Self-checking bench for mem_loader: table of images plus hand sequences for stall,
// mid-word reset and (with LOADER_CHECKSUM_EN) checksum pass/fail.

module tb_mem_loader;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_ready;
    logic        memwrite;
    logic [31:0] dataadr;
    logic [31:0] writedata;
    logic        core_reset;
    logic        busy;
    logic        done;
    logic        err;

    always #5 clk = ~clk;

    mem_loader #(.BASE_ADDR(32'h0000_0000), .MAX_WORDS(131072)) dut (
        .clk(clk), .reset(reset), .rx_valid(rx_valid), .rx_data(rx_data),
        .rx_ready(rx_ready), .memwrite(memwrite), .dataadr(dataadr),
        .writedata(writedata), .core_reset(core_reset), .busy(busy),
        .done(done), .err(err)
    );

    typedef struct {
        int          hdr;
        int          nw;
        logic [31:0] seed;
        logic [31:0] step;
        bit          exp_err;
        bit          gap5;
    } vec_t;

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;
    int wr_count = 0;
    int done_cyc = 0;
    int last_wr_cyc = 0;
    bit done_seen = 0;
    bit prev_mw = 0;
    logic [63:0] exp_q[$];
    int wr_cyc[$];
    logic [31:0] mem [0:15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    always @(posedge clk) cyc++;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 16; i++) mem[i] <= 32'd0;
        end else if (memwrite && dataadr < 32'd64) begin
            mem[dataadr[5:2]] <= writedata;
        end
    end

    // Scoreboard monitor: every strobe must match the oldest queued expectation.
    always @(negedge clk) begin
        if (reset) begin
            if (memwrite) begin
                logic [63:0] e;
                chk("memwrite_back_to_back", {31'd0, prev_mw}, 32'd0);
                chk("write_expected", {31'd0, exp_q.size() != 0}, 32'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("dataadr", dataadr, e[63:32]);
                    chk("writedata", writedata, e[31:0]);
                end
                wr_count++;
                wr_cyc.push_back(cyc);
                last_wr_cyc = cyc;
            end
            if (done && !done_seen) begin
                done_seen = 1;
                done_cyc = cyc;
            end
            prev_mw = memwrite;
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int t = 0;
        @(negedge clk);
        rx_valid = 1'b1;
        rx_data = b;
        while (!rx_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!rx_ready) chk("rx_ready_timeout", {31'd0, rx_ready}, 32'd1);
        @(posedge clk);
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
    endtask

    task automatic send_image(input int hdr, input int nw, input logic [31:0] seed,
                              input logic [31:0] step);
        logic [31:0] sum = 32'd0;
        logic [31:0] w;
        send_word(hdr);
        for (int i = 0; i < nw; i++) begin
            w = seed + step * i;
            exp_q.push_back({32'(4 * i), w});
            sum = sum + w;
            send_word(w);
        end
`ifdef LOADER_CHECKSUM_EN
        if (nw > 0) send_word(sum);
`endif
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        #3;
        rx_valid = 1'b0;
        reset = 1'b0;
        #1;
        chk("rst_memwrite", {31'd0, memwrite}, 32'd0);
        chk("rst_dataadr", dataadr, 32'h0000_0000);
        chk("rst_writedata", writedata, 32'd0);
        chk("rst_core_reset", {31'd0, core_reset}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_rx_ready", {31'd0, rx_ready}, 32'd0);
        exp_q.delete();
        wr_cyc.delete();
        wr_count = 0;
        done_seen = 0;
        prev_mw = 0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("rx_ready_after_reset", {31'd0, rx_ready}, 32'd1);
    endtask

    task automatic wait_end();
        int t = 0;
        while (!(done || err) && t < 400) begin
            @(negedge clk);
            t++;
        end
        chk("end_reached", {31'd0, done | err}, 32'd1);
    endtask

    task automatic finish_image(input bit exp_err, input int nw, input logic [31:0] seed,
                                input logic [31:0] step, input bit gap5);
        @(negedge clk);
        chk("done", {31'd0, done}, {31'd0, !exp_err});
        chk("err", {31'd0, err}, {31'd0, exp_err});
        chk("core_reset", {31'd0, core_reset}, {31'd0, exp_err});
        chk("busy_end", {31'd0, busy}, 32'd0);
        chk("rx_ready_end", {31'd0, rx_ready}, 32'd0);
        chk("write_count", wr_count, nw);
        chk("queue_left", exp_q.size(), 32'd0);
        for (int i = 0; i < nw && i < 16; i++) chk("mem_readback", mem[i], seed + step * i);
        if (gap5)
            for (int i = 1; i < wr_cyc.size(); i++)
                chk("write_spacing", wr_cyc[i] - wr_cyc[i-1], 32'd5);
`ifndef LOADER_CHECKSUM_EN
        if (!exp_err) chk("done_latency", done_cyc - last_wr_cyc, 32'd1);
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t vecs[5];
        logic [31:0] w0;
        logic [31:0] w1;
        vecs[0] = '{hdr: 1,      nw: 1, seed: 32'h1234_5678, step: 32'h0,         exp_err: 0, gap5: 1};
        vecs[1] = '{hdr: 3,      nw: 3, seed: 32'h1111_1111, step: 32'h1111_1111, exp_err: 0, gap5: 1};
        vecs[2] = '{hdr: 0,      nw: 0, seed: 32'h0,         step: 32'h0,         exp_err: 1, gap5: 0};
        vecs[3] = '{hdr: 131073, nw: 0, seed: 32'h0,         step: 32'h0,         exp_err: 1, gap5: 0};
        vecs[4] = '{hdr: 5,      nw: 5, seed: 32'hDEAD_BEEF, step: 32'h0101_0101, exp_err: 0, gap5: 1};

        for (int v = 0; v < 5; v++) begin
            do_reset();
            send_image(vecs[v].hdr, vecs[v].nw, vecs[v].seed, vecs[v].step);
            wait_end();
            finish_image(vecs[v].exp_err, vecs[v].nw, vecs[v].seed, vecs[v].step, vecs[v].gap5);
        end

        // rx_valid drops for 3 cycles between bytes 2 and 3 of word 0
        w0 = 32'hA1B2_C3D4;
        w1 = 32'h0F0E_0D0C;
        do_reset();
        send_word(32'd2);
        exp_q.push_back({32'h0, w0});
        send_byte(w0[7:0]);
        send_byte(w0[15:8]);
        @(negedge clk);
        rx_valid = 1'b0;
        repeat (3) @(negedge clk);
        send_byte(w0[23:16]);
        send_byte(w0[31:24]);
        exp_q.push_back({32'h4, w1});
        send_word(w1);
`ifdef LOADER_CHECKSUM_EN
        send_word(w0 + w1);
`endif
        @(negedge clk);
        rx_valid = 1'b0;
        wait_end();
        finish_image(0, 2, w0, w1 - w0, 0);

        // reset asserted mid-word during word 1 of an N=4 image, then a fresh N=1 image
        do_reset();
        send_word(32'd4);
        exp_q.push_back({32'h0, 32'h5555_AAAA});
        send_word(32'h5555_AAAA);
        send_byte(8'h77);
        send_byte(8'h66);
        do_reset();
        chk("mem_cleared", mem[0], 32'd0);
        send_image(1, 1, 32'hCAFE_F00D, 32'h0);
        wait_end();
        finish_image(0, 1, 32'hCAFE_F00D, 32'h0, 1);

`ifdef LOADER_CHECKSUM_EN
        for (int k = 0; k < 2; k++) begin
            do_reset();
            send_word(32'd2);
            exp_q.push_back({32'h0, 32'd1});
            send_word(32'd1);
            exp_q.push_back({32'h4, 32'd2});
            send_word(32'd2);
            send_word(k == 0 ? 32'd3 : 32'd4);
            @(negedge clk);
            rx_valid = 1'b0;
            wait_end();
            finish_image(k == 1, 2, 32'd1, 32'd1, 1);
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
